// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = MULT_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_e;

endpackage

// File: rtl/booth_recode4.sv
// Radix-4 Booth recoder: maps a 3-bit overlapping multiplier group to a partial-product select.
module booth_recode4
    import mult_pkg::*;
(
    input  logic [2:0]  grp,
    output booth_sel_e  sel,
    output logic        neg
);

    // Recode one Booth group into magnitude select and negate flag
    always_comb begin
        sel = SEL_ZERO;
        neg = 1'b0;
        case (grp)
            3'b000, 3'b111: begin sel = SEL_ZERO; neg = 1'b0; end
            3'b001, 3'b010: begin sel = SEL_POS1; neg = 1'b0; end
            3'b011:         begin sel = SEL_POS2; neg = 1'b0; end
            3'b100:         begin sel = SEL_NEG2; neg = 1'b1; end
            3'b101, 3'b110: begin sel = SEL_NEG1; neg = 1'b1; end
            default:        begin sel = SEL_ZERO; neg = 1'b0; end
        endcase
    end

endmodule

// File: rtl/booth_mult32.sv
// Multi-cycle signed radix-4 Booth multiplier: one Booth step per cycle, registered
// truncated product with signed-overflow flag and a one-cycle ready strobe.
module booth_mult32
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int ITERS = WIDTH / 2;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int PW    = 2 * WIDTH + 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    mult_state_e       state_q, state_d;
    logic [PW-1:0]     p_q, p_d;
    logic [WIDTH+1:0]  m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;

    booth_sel_e        sel;
    logic              neg;
    logic [WIDTH+1:0]  mag;
    logic [WIDTH+1:0]  term;
    logic [WIDTH+1:0]  sum;
    logic [PW-1:0]     p_shift;
    logic [2*WIDTH-1:0] q;

    booth_recode4 u_recode (
        .grp (p_q[2:0]),
        .sel (sel),
        .neg (neg)
    );

    // Partial-product term and one accumulate-and-shift Booth step
    always_comb begin
        mag = '0;
        case (sel)
            SEL_POS1, SEL_NEG1: mag = m_q;
            SEL_POS2, SEL_NEG2: mag = {m_q[WIDTH:0], 1'b0};
            SEL_ZERO:           mag = '0;
            default:            mag = '0;
        endcase
        if (neg) begin
            term = ~mag + (WIDTH+2)'(1);
        end else begin
            term = mag;
        end
        sum     = p_q[PW-1:WIDTH+1] + term;
        p_shift = {{2{sum[WIDTH+1]}}, sum, p_q[WIDTH:2]};
        q       = p_shift[2*WIDTH:1];
    end

    // Next-state: a start pulse always wins and restarts from fresh operands
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (ctrl_mult) begin
            m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
            p_d     = {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    p_d   = p_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_d = q[WIDTH-1:0];
                        exc_d    = !((q[2*WIDTH-1:WIDTH-1] == '0) ||
                                     (q[2*WIDTH-1:WIDTH-1] == '1));
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_busy      = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult32.sv
// Self-checking bench for booth_mult32: an abstract latency/arithmetic model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_booth_mult32;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_mult = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    booth_mult32 #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_vec = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return sx * sy;
    endfunction

    function automatic logic ovf(input longint p);
        logic [31:0] lo;
        lo = p[31:0];
        return p != longint'($signed(lo));
    endfunction

    // Reference model: a started product appears ITERS edges later unless restarted or reset
    logic        m_valid = 1'b0;
    int          m_rem = 0;
    longint      m_prod = 64'sd0;
    logic [31:0] m_res = 32'd0;
    logic        m_exc = 1'b0;
    logic        m_rdy = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_rem   <= 0;
            m_res   <= 32'd0;
            m_exc   <= 1'b0;
            m_rdy   <= 1'b0;
        end else if (ctrl_mult) begin
            m_prod <= mul(op_a, op_b);
            m_rem  <= MULT_ITERS;
            m_rdy  <= 1'b0;
        end else if (m_rem == 1) begin
            m_res <= m_prod[31:0];
            m_exc <= ovf(m_prod);
            m_rdy <= 1'b1;
            m_rem <= 0;
        end else begin
            m_rdy <= 1'b0;
            if (m_rem > 0) m_rem <= m_rem - 1;
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            chk("rdy",    data_resultRDY, m_rdy);
            chk("busy",   data_busy, (m_rem > 0));
            chk("result", data_result, m_res);
            chk("exc",    data_exception, m_exc);
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = 1'b1;
        op_a = a;
        op_b = b;
        n_vec++;
        @(negedge clk);
        ctrl_mult = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic wait_rdy(input string name, input logic [31:0] er, input logic ee);
        int   cyc;
        int   busy_cnt;
        logic seen;
        cyc = 0;
        seen = 1'b0;
        busy_cnt = data_busy ? 1 : 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (data_resultRDY) seen = 1'b1;
            if (data_busy) busy_cnt++;
        end
        chk({name, "_strobe_seen"}, seen, 1'b1);
        if (seen) begin
            chk({name, "_latency"}, cyc, MULT_ITERS);
            chk({name, "_result"},  data_result, er);
            chk({name, "_exc"},     data_exception, ee);
            chk({name, "_model"},   {m_exc, m_res}, {ee, er});
        end
        chk({name, "_busy_cycles"}, busy_cnt, MULT_ITERS);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t dir_vecs[6];

    initial begin
        dir_vecs[0] = '{32'd6,          32'd7,          32'd42,         1'b0};
        dir_vecs[1] = '{32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, 1'b0};
        dir_vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        dir_vecs[3] = '{32'h7FFF_FFFF, 32'd2,          32'hFFFF_FFFE, 1'b1};
        dir_vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        dir_vecs[5] = '{32'h0000_8000, 32'hFFFF_0000, 32'h8000_0000, 1'b0};

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc",    data_exception, 1'b0);
        chk("reset_rdy",    data_resultRDY, 1'b0);
        chk("reset_busy",   data_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_op(dir_vecs[i].a, dir_vecs[i].b);
            wait_rdy($sformatf("dir%0d", i), dir_vecs[i].res, dir_vecs[i].exc);
            @(negedge clk);
        end

        // Abort: restart with 9x9 after 8 iterations of 3x4
        start_op(32'd3, 32'd4);
        repeat (8) @(negedge clk);
        start_op(32'd9, 32'd9);
        wait_rdy("abort", 32'd81, 1'b0);
        @(negedge clk);

        // Reset after 10 iterations of 5x5
        start_op(32'd5, 32'd5);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exc",    data_exception, 1'b0);
        chk("midreset_rdy",    data_resultRDY, 1'b0);
        chk("midreset_busy",   data_busy, 1'b0);
        repeat (25) begin
            @(negedge clk);
            chk("midreset_no_strobe", data_resultRDY, 1'b0);
        end
        start_op(32'd2, 32'd3);
        wait_rdy("after_reset", 32'd6, 1'b0);
        @(negedge clk);

        // Back-to-back: new start during the DONE cycle of 1x1
        start_op(32'd1, 32'd1);
        wait_rdy("b2b_first", 32'd1, 1'b0);
        start_op(32'd10, 32'hFFFF_FFF6);
        wait_rdy("b2b_second", 32'hFFFF_FF9C, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            longint      p;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) ra = ra >> $urandom_range(0, 31);
            p = mul(ra, rb);
            start_op(ra, rb);
            wait_rdy("rand", p[31:0], ovf(p));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
